toff_mux_pipe: RTL and testbench

TOFF_MUX_PIPE -- requirements
Module: toff_mux_pipe

---
 rtl/toff_mux_pipe.sv | 153 +++++++++++++++
 tb/tb_toff_mux_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toff_mux_pipe.sv
// Purpose : CH-to-1 channel mux built Toffoli-style: select decoded to a one-hot onto zero ancillas, then XOR-of-ANDs.
// Latency : 2 registered stages; a beat presented with in_valid=1 appears on out_valid two cycles later when not stalled.
// Backpressure: valid/ready; each stage refills in the same cycle it drains, in_ready drops only when both stages are full and out_ready=0.
//
// Ports:
//   clk, rst                 single clock, asynchronous active-high reset
//   in_valid / in_ready      input handshake; data_in carries CH channels, channel k at [k*WIDTH +: WIDTH]
//   sel, auto_scan           manual channel select, or round-robin scan counter when auto_scan=1
//   out_valid / out_ready    output handshake; data_out is the selected channel, sel_out its index
//   anc_err                  sticky: stage-2 saw a one-hot with other than exactly one bit set
module toff_mux_pipe #(
    parameter int WIDTH = 4,
    parameter int CH    = 4,
    localparam int SW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH*WIDTH-1:0]   data_in,
    input  logic [SW-1:0]         sel,
    input  logic                  auto_scan,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic [SW-1:0]         sel_out,
    output logic                  anc_err
);

    // Stage-1 payload: raw channels plus the decoded one-hot and the index it came from.
    typedef struct packed {
        logic [CH*WIDTH-1:0] dat;
        logic [CH-1:0]       onehot;
        logic [SW-1:0]       sel;
    } s1_t;

    // Stage-2 payload: the muxed result as presented on the outputs.
    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [SW-1:0]    sel;
    } s2_t;

    logic [SW-1:0] scan_q, scan_d;
    logic          s1_vld_q, s1_vld_d;
    s1_t           s1_q, s1_d;
    logic          s2_vld_q, s2_vld_d;
    s2_t           s2_q, s2_d;
    logic          anc_err_q, anc_err_d;

    logic          s2_adv;
    logic          s1_rdy;
    logic          in_acc;
    logic [SW-1:0] eff_sel;
    logic [CH-1:0] onehot_dec;
    logic [WIDTH-1:0] mux_dat;
    logic [SW:0]   hot_cnt;
    logic          onehot_ok;

    // Stage 2 can take a new beat when empty or when its current beat is popped;
    // stage 1 can take a new beat when empty or when its beat moves into stage 2.
    assign s2_adv  = !s2_vld_q || out_ready;
    assign s1_rdy  = !s1_vld_q || s2_adv;
    assign in_acc  = in_valid && s1_rdy;
    assign eff_sel = auto_scan ? scan_q : sel;

    // Stage-1 decode: each ancilla starts at 0 and is flipped by a multi-controlled
    // NOT whose controls are the select bits matched (XNOR) against index k.
    always_comb begin
        onehot_dec = '0;
        for (int k = 0; k < CH; k++) begin
            onehot_dec[k] = 1'b0 ^ (&(eff_sel ~^ SW'(k)));
        end
    end

    // Stage-2 combine: every channel is a Toffoli onto a zero target, gated by its
    // one-hot bit; the targets are XOR-accumulated into the result.
    always_comb begin
        mux_dat = '0;
        for (int k = 0; k < CH; k++) begin
            mux_dat = mux_dat ^ (s1_q.dat[k*WIDTH +: WIDTH] & {WIDTH{s1_q.onehot[k]}});
        end
    end

    // Ancilla check: the one-hot must have exactly one bit set.
    always_comb begin
        hot_cnt = '0;
        for (int k = 0; k < CH; k++) begin
            hot_cnt = hot_cnt + (SW+1)'(s1_q.onehot[k]);
        end
        onehot_ok = (hot_cnt == (SW+1)'(1));
    end

    // Next-state logic for the scan counter and both stages.
    always_comb begin
        scan_d    = scan_q;
        s1_vld_d  = s1_vld_q;
        s1_d      = s1_q;
        s2_vld_d  = s2_vld_q;
        s2_d      = s2_q;
        anc_err_d = anc_err_q;

        // The counter only moves on beats that actually consumed its value.
        if (in_acc && auto_scan) begin
            scan_d = scan_q + SW'(1);
        end

        if (s1_rdy) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_d.dat    = data_in;
                s1_d.onehot = onehot_dec;
                s1_d.sel    = eff_sel;
            end
        end

        // Payload is only rewritten for a real beat so outputs hold while idle.
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_d.dat = mux_dat;
                s2_d.sel = s1_q.sel;
                if (!onehot_ok) begin
                    anc_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_q    <= '0;
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            s2_vld_q  <= 1'b0;
            s2_q      <= '0;
            anc_err_q <= 1'b0;
        end else begin
            scan_q    <= scan_d;
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            s2_vld_q  <= s2_vld_d;
            s2_q      <= s2_d;
            anc_err_q <= anc_err_d;
        end
    end

    assign in_ready  = s1_rdy;
    assign out_valid = s2_vld_q;
    assign data_out  = s2_q.dat;
    assign sel_out   = s2_q.sel;
    assign anc_err   = anc_err_q;

endmodule

// File: tb/tb_toff_mux_pipe.sv
// Purpose : scoreboard bench for toff_mux_pipe (WIDTH=4, CH=4).
// Latency : expects each beat two cycles after it is presented, one output per cycle when unstalled.
// Backpressure: drives out_ready low to fill the pipe and checks in_ready and output hold.
module tb_toff_mux_pipe;

    localparam int WIDTH = 4;
    localparam int CH    = 4;
    localparam int SW    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [CH*WIDTH-1:0] data_in;
    logic [SW-1:0]       sel;
    logic                auto_scan;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    data_out;
    logic [SW-1:0]       sel_out;
    logic                anc_err;

    always #5 clk = ~clk;

    toff_mux_pipe #(.WIDTH(WIDTH), .CH(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .sel       (sel),
        .auto_scan (auto_scan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .anc_err   (anc_err)
    );

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic [SW-1:0]    sel;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [SW-1:0] tb_scan = '0;
    bit            mon_en = 1'b0;

    // Output scoreboard: every popped beat must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected: got data=%h sel=%0d, required no output", data_out, sel_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.dat || sel_out !== e.sel) begin
                    errors++;
                    $display("FAIL mon_beat: got data=%h sel=%0d, required data=%h sel=%0d",
                             data_out, sel_out, e.dat, e.sel);
                end
            end
        end
    end

    // Offer one beat and hold it until accepted; the expectation is pushed on acceptance.
    task automatic drive_beat(input logic [CH*WIDTH-1:0] d, input logic [SW-1:0] s,
                              input logic scan, output int waited);
        logic [SW-1:0] es;
        bit            done;
        data_in   = d;
        sel       = s;
        auto_scan = scan;
        in_valid  = 1'b1;
        waited    = 0;
        done      = 1'b0;
        while (!done && waited < 50) begin
            @(negedge clk);
            waited++;
            if (in_ready) begin
                es = scan ? tb_scan : s;
                exp_q.push_back(exp_t'{dat: d[es*WIDTH +: WIDTH], sel: es});
                if (scan) tb_scan = tb_scan + 2'd1;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drive_timeout: beat not accepted after %0d cycles, required acceptance", waited);
        end
    endtask

    task automatic drain(input string name);
        int n;
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats still pending, required 0", name, exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        exp_q.delete();
        tb_scan = '0;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        sel       = '0;
        auto_scan = 1'b0;
        out_ready = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 4'h0 || sel_out !== 2'd0 || anc_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h sel=%0d err=%b, required 0 0 0 0",
                     out_valid, data_out, sel_out, anc_err);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_single_beat();
        logic [CH*WIDTH-1:0] d;
        d = 16'hDCBA;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        data_in = d; sel = 2'd2; auto_scan = 1'b0; in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_in_ready: got %b, required 1", in_ready);
        end
        exp_q.push_back(exp_t'{dat: d[2*WIDTH +: WIDTH], sel: 2'd2});
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: out_valid got %b one cycle in, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || data_out !== 4'hC || sel_out !== 2'd2) begin
            errors++;
            $display("FAIL single_out: got valid=%b data=%h sel=%0d, required 1 c 2",
                     out_valid, data_out, sel_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_one_cycle: out_valid got %b, required 0", out_valid);
        end
        drain("single");
    endtask

    task automatic test_scan();
        int w;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_beat(16'h4321, 2'd0, 1'b1, w);
            checks++;
            if (w != 1) begin
                errors++;
                $display("FAIL scan_b2b: beat %0d took %0d cycles, required 1", i, w);
            end
        end
        drain("scan");
    endtask

    task automatic test_backpressure();
        int w;
        out_ready = 1'b0;
        drive_beat(16'h8765, 2'd1, 1'b0, w);
        drive_beat(16'h8765, 2'd2, 1'b0, w);
        data_in = 16'h8765; sel = 2'd3; auto_scan = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready: cycle %0d got %b, required 0", i, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || data_out !== 4'h6 || sel_out !== 2'd1) begin
                errors++;
                $display("FAIL bp_hold: got valid=%b data=%h sel=%0d, required 1 6 1",
                         out_valid, data_out, sel_out);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive_beat(16'h8765, 2'd3, 1'b0, w);
        checks++;
        if (w != 1) begin
            errors++;
            $display("FAIL bp_resume: third beat took %0d cycles, required 1", w);
        end
        drain("bp");
    endtask

    task automatic test_scan_toggle();
        int w;
        do_reset();
        out_ready = 1'b1;
        drive_beat(16'hFEDC, 2'd1, 1'b1, w);
        drive_beat(16'hFEDC, 2'd1, 1'b1, w);
        drive_beat(16'hFEDC, 2'd3, 1'b0, w);
        drive_beat(16'hFEDC, 2'd0, 1'b0, w);
        drive_beat(16'hFEDC, 2'd1, 1'b1, w);
        drain("toggle");
        checks++;
        if (anc_err !== 1'b0) begin
            errors++;
            $display("FAIL toggle_anc: got %b, required 0", anc_err);
        end
    endtask

    task automatic test_reset_midstream();
        int w;
        do_reset();
        out_ready = 1'b0;
        drive_beat(16'h4321, 2'd0, 1'b1, w);
        drive_beat(16'h4321, 2'd0, 1'b1, w);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || data_out !== 4'h0 || sel_out !== 2'd0 || anc_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got valid=%b data=%h sel=%0d err=%b, required 0 0 0 0",
                     out_valid, data_out, sel_out, anc_err);
        end
        exp_q.delete();
        tb_scan = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        repeat (4) @(posedge clk);
        #1;
        drive_beat(16'h4321, 2'd3, 1'b1, w);
        drain("midrst");
        checks++;
        if (anc_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_anc: got %b, required 0", anc_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_scan();
        test_backpressure();
        test_scan_toggle();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

endmodule
